// File: rtl/motion_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motion_detect_pkg
// Description : Shared widths, pixel type and output-mode encoding for the
//               streaming motion detector.
// Revision    : 1.0 - initial release
// ============================================================================
package motion_detect_pkg;

  localparam int CH_W_DEF   = 8;
  localparam int NUM_CH_DEF = 3;
  localparam int PIX_W_DEF  = CH_W_DEF * NUM_CH_DEF;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    HIGHLIGHT = 2'd0,
    MASK      = 2'd1,
    PASS      = 2'd2,
    DIFF      = 2'd3
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/motion_detect_stream_gray.sv
`default_nettype none
// ============================================================================
// Module      : motion_gray
// Description : Combinational grayscale: truncating average of all channels.
// Revision    : 1.0 - initial release
// ============================================================================
module motion_gray
  import motion_detect_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic [CH_W*NUM_CH-1:0] pix,
  output logic [CH_W-1:0]        gray
);

  // Wide enough that NUM_CH full-scale channels cannot overflow the sum
  localparam int SUM_W = CH_W + $clog2(NUM_CH + 1);

  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_avg;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = w_sum + SUM_W'(pix[i*CH_W +: CH_W]);
    end
  end

  assign w_avg = w_sum / SUM_W'(NUM_CH);
  assign gray  = w_avg[CH_W-1:0];

endmodule
`default_nettype wire

// File: rtl/motion_detect_stream.sv
`default_nettype none
// ============================================================================
// Module      : motion_detect_stream
// Description : 3-stage streaming motion detector between three input FIFOs
//               and one output FIFO, with per-frame motion count.
// Revision    : 1.0 - initial release
// ============================================================================
module motion_detect_stream
  import motion_detect_pkg::*;
#(
  parameter int CH_W       = CH_W_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int CNT_W      = 20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CH_W*NUM_CH-1:0] frame_dout,
  input  logic                   frame_empty,
  output logic                   frame_rd_en,
  input  logic [CH_W*NUM_CH-1:0] hold_dout,
  input  logic                   hold_empty,
  output logic                   hold_rd_en,
  input  logic [CH_W*NUM_CH-1:0] base_dout,
  input  logic                   base_empty,
  output logic                   base_rd_en,
  output logic [CH_W*NUM_CH-1:0] out_din,
  input  logic                   out_full,
  output logic                   out_wr_en,
  input  logic [CH_W-1:0]        threshold,
  input  logic [1:0]             mode,
  input  logic [CH_W*NUM_CH-1:0] hl_color,
  output logic [CNT_W-1:0]       motion_count,
  output logic                   frame_done
);

  localparam int PIX_W = CH_W * NUM_CH;
  localparam int X_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int Y_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [X_W-1:0] C_X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic             w_advance, w_pop, w_push, w_in_first, w_out_last;
  logic [CH_W-1:0]  w_gray_f, w_gray_b, w_diff, w_cfg_thr;
  logic [PIX_W-1:0] w_cfg_hl, w_result;
  mode_e            w_cfg_mode;

  logic [X_W-1:0]   r_in_x, r_out_x;
  logic [Y_W-1:0]   r_in_y, r_out_y;
  logic [CH_W-1:0]  r_thr_lat;
  mode_e            r_mode_lat;
  logic [PIX_W-1:0] r_hl_lat;

  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic [CH_W-1:0]  r_s1_gf, r_s1_gb, r_s1_thr, r_s2_diff;
  logic [PIX_W-1:0] r_s1_hold, r_s1_hl, r_s2_hold, r_s2_hl, r_s3_pix;
  mode_e            r_s1_mode, r_s2_mode;
  logic             r_s2_motion, r_s3_motion;
  logic [CNT_W-1:0] r_run, r_motion_count;

  // Pop is gated by reset so the FIFOs are left untouched while it is held
  assign w_advance   = !r_s3_valid || !out_full;
  assign w_pop       = reset && w_advance && !frame_empty && !hold_empty && !base_empty;
  assign frame_rd_en = w_pop;
  assign hold_rd_en  = w_pop;
  assign base_rd_en  = w_pop;
  assign w_push      = r_s3_valid && !out_full;
  assign out_wr_en   = w_push;
  assign out_din     = r_s3_pix;

  assign w_in_first  = (r_in_x == '0) && (r_in_y == '0);
  assign w_out_last  = (r_out_x == C_X_LAST) && (r_out_y == C_Y_LAST);
  assign frame_done  = w_push && w_out_last;
  assign motion_count = r_motion_count;

  // Pixel (0,0) takes the live config; the latch keeps it for the frame rest
  assign w_cfg_thr  = w_in_first ? threshold      : r_thr_lat;
  assign w_cfg_mode = w_in_first ? mode_e'(mode)  : r_mode_lat;
  assign w_cfg_hl   = w_in_first ? hl_color       : r_hl_lat;

  motion_gray #(.CH_W(CH_W), .NUM_CH(NUM_CH)) u_gray_frame (
    .pix  (frame_dout),
    .gray (w_gray_f)
  );

  motion_gray #(.CH_W(CH_W), .NUM_CH(NUM_CH)) u_gray_base (
    .pix  (base_dout),
    .gray (w_gray_b)
  );

  assign w_diff = (r_s1_gf >= r_s1_gb) ? (r_s1_gf - r_s1_gb) : (r_s1_gb - r_s1_gf);

  always_comb begin
    w_result = r_s2_hold;
    case (r_s2_mode)
      HIGHLIGHT: w_result = r_s2_motion ? r_s2_hl : r_s2_hold;
      MASK:      w_result = r_s2_motion ? {PIX_W{1'b1}} : '0;
      PASS:      w_result = r_s2_hold;
      DIFF:      w_result = {NUM_CH{r_s2_diff}};
      default:   w_result = r_s2_hold;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_x     <= '0;
      r_in_y     <= '0;
      r_thr_lat  <= '0;
      r_mode_lat <= HIGHLIGHT;
      r_hl_lat   <= '0;
    end else if (w_pop) begin
      if (w_in_first) begin
        r_thr_lat  <= threshold;
        r_mode_lat <= mode_e'(mode);
        r_hl_lat   <= hl_color;
      end
      if (r_in_x == C_X_LAST) begin
        r_in_x <= '0;
        r_in_y <= (r_in_y == C_Y_LAST) ? '0 : r_in_y + 1'b1;
      end else begin
        r_in_x <= r_in_x + 1'b1;
      end
    end
  end

  // Config travels alongside each pixel so a frame boundary inside the
  // pipeline never mixes settings of two frames
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_gf     <= '0;
      r_s1_gb     <= '0;
      r_s1_hold   <= '0;
      r_s1_thr    <= '0;
      r_s1_mode   <= HIGHLIGHT;
      r_s1_hl     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_diff   <= '0;
      r_s2_motion <= 1'b0;
      r_s2_hold   <= '0;
      r_s2_mode   <= HIGHLIGHT;
      r_s2_hl     <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_pix    <= '0;
      r_s3_motion <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= w_pop;
      r_s1_gf     <= w_gray_f;
      r_s1_gb     <= w_gray_b;
      r_s1_hold   <= hold_dout;
      r_s1_thr    <= w_cfg_thr;
      r_s1_mode   <= w_cfg_mode;
      r_s1_hl     <= w_cfg_hl;
      r_s2_valid  <= r_s1_valid;
      r_s2_diff   <= w_diff;
      r_s2_motion <= (w_diff > r_s1_thr);
      r_s2_hold   <= r_s1_hold;
      r_s2_mode   <= r_s1_mode;
      r_s2_hl     <= r_s1_hl;
      r_s3_valid  <= r_s2_valid;
      r_s3_pix    <= w_result;
      r_s3_motion <= r_s2_motion;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_x        <= '0;
      r_out_y        <= '0;
      r_run          <= '0;
      r_motion_count <= '0;
    end else if (w_push) begin
      if (r_out_x == C_X_LAST) begin
        r_out_x <= '0;
        r_out_y <= (r_out_y == C_Y_LAST) ? '0 : r_out_y + 1'b1;
      end else begin
        r_out_x <= r_out_x + 1'b1;
      end
      if (w_out_last) begin
        r_motion_count <= r_run + CNT_W'(r_s3_motion);
        r_run          <= '0;
      end else begin
        r_run <= r_run + CNT_W'(r_s3_motion);
      end
    end
  end

endmodule
`default_nettype wire
